// File: rtl/mult_stream_mac.sv
// mult_stream_mac: pipelined signed lane multiplier with per-map accumulate mode
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   mode                  0 = stream products, 1 = accumulate over map (sampled on beat 0)
//   in_valid / in_ready   input handshake; a, b carry LANES signed operands each
//   out_valid / out_ready output handshake; out_data carries LANES signed ACC_WIDTH results
//   out_last              final output beat of the current map
module mult_stream_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int MAP_SIZE = 32,
    parameter int LANES = 32,
    localparam int BEATS = MAP_SIZE * MAP_SIZE / LANES,
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(BEATS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]  a,
    input  logic [LANES*DATA_WIDTH-1:0]  b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ACC_WIDTH-1:0]   out_data,
    output logic                         out_last
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
    logic [CW-1:0]                r_cnt;
    logic                         r_map_mode;
    logic [LANES*DATA_WIDTH-1:0]  r_a, r_b;
    logic                         r_v1, r_first1, r_last1, r_mode1;
    logic [LANES*ACC_WIDTH-1:0]   r_acc, r_out_data;
    logic                         r_out_valid, r_out_last;
    logic                         w_stall, w_take, w_mode, w_emit;
    logic [LANES*ACC_WIDTH-1:0]   w_ext, w_acc_nxt;
    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign w_take    = in_valid & in_ready;
    // beat 0 takes the live mode pin; later beats reuse the value latched at beat 0
    assign w_mode    = (r_cnt == '0) ? mode : r_map_mode;
    // mode 1 emits only on the map's last beat
    assign w_emit    = r_v1 & (~r_mode1 | r_last1);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    always_comb begin
        w_ext = '0;
        w_acc_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            logic signed [DATA_WIDTH-1:0] w_x, w_y;
            logic signed [PW-1:0]         w_p;
            logic signed [ACC_WIDTH-1:0]  w_pe;
            w_x = r_a[i*DATA_WIDTH +: DATA_WIDTH];
            w_y = r_b[i*DATA_WIDTH +: DATA_WIDTH];
            w_p = PW'(w_x) * PW'(w_y);
            w_pe = ACC_WIDTH'(w_p);
            w_ext[i*ACC_WIDTH +: ACC_WIDTH] = w_pe;
            w_acc_nxt[i*ACC_WIDTH +: ACC_WIDTH] = (r_first1 ? '0 : r_acc[i*ACC_WIDTH +: ACC_WIDTH]) + w_pe;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_map_mode  <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_v1        <= 1'b0;
            r_first1    <= 1'b0;
            r_last1     <= 1'b0;
            r_mode1     <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_take) begin
                r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CW'(1);
                if (r_cnt == '0) r_map_mode <= mode;
            end
            if (!w_stall) begin
                r_a         <= a;
                r_b         <= b;
                r_v1        <= in_valid;
                r_first1    <= (r_cnt == '0);
                r_last1     <= (r_cnt == LAST_CNT);
                r_mode1     <= w_mode;
                if (r_v1 && r_mode1) r_acc <= w_acc_nxt;
                r_out_valid <= w_emit;
                if (w_emit) begin
                    r_out_data <= r_mode1 ? w_acc_nxt : w_ext;
                    r_out_last <= r_mode1 | r_last1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_stream_mac.sv
// tb_mult_stream_mac: directed self-checking bench for mult_stream_mac (4x4 map, 4 lanes, 8-bit operands)
module tb_mult_stream_mac;
    localparam int AW = 18;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [71:0] out_data;
    logic        out_last;
    int          n_err = 0, n_checks = 0;
    logic [71:0] q_data[$];
    logic        q_last[$];
    logic [71:0] snap;
    mult_stream_mac #(.DATA_WIDTH(8), .MAP_SIZE(4), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
        end
    end
    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction
    function automatic longint lane(input logic [71:0] d, input int i);
        logic [AW-1:0] x;
        x = d[i*AW +: AW];
        return longint'($signed(x));
    endfunction
    task automatic send(input logic m, input logic [31:0] av, input logic [31:0] bv);
        logic ok;
        int tries;
        mode = m;
        a = av;
        b = bv;
        in_valid = 1'b1;
        tries = 0;
        do begin
            #4 ok = in_ready;
            @(posedge clk);
            @(negedge clk);
            tries++;
        end while (!ok && tries < 50);
        if (!ok) check("accept_timeout", 0, 1);
    endtask
    task automatic drain();
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
    endtask
    task automatic chk_beat(input string tag, input int idx, input longint e0, input longint e1,
                            input longint e2, input longint e3, input logic el);
        if (idx < q_data.size()) begin
            check($sformatf("%s[%0d].l0", tag, idx), lane(q_data[idx], 0), e0);
            check($sformatf("%s[%0d].l1", tag, idx), lane(q_data[idx], 1), e1);
            check($sformatf("%s[%0d].l2", tag, idx), lane(q_data[idx], 2), e2);
            check($sformatf("%s[%0d].l3", tag, idx), lane(q_data[idx], 3), e3);
            check($sformatf("%s[%0d].last", tag, idx), longint'(q_last[idx]), longint'(el));
        end else begin
            check($sformatf("%s[%0d].missing", tag, idx), 0, 1);
        end
    endtask
    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data != 0), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_last", longint'(out_last), 0);
        rst_n = 1'b1;
        @(negedge clk);
        // T2: mode 0 stream, latency and products
        q_data.delete(); q_last.delete();
        send(0, pk(-128, 127, 5, -3), pk(-128, -128, 7, 9));
        check("t2_lat1_valid", longint'(out_valid), 0);
        send(0, pk(1, 2, 3, 4), pk(10, 20, 30, 40));
        check("t2_lat2_valid", longint'(out_valid), 1);
        check("t2_lat2_l0", lane(out_data, 0), 16384);
        send(0, pk(-1, -1, 0, 100), pk(1, -1, 55, -100));
        send(0, pk(127, 127, -128, 2), pk(127, -1, 1, -2));
        drain();
        check("t2_count", q_data.size(), 4);
        chk_beat("t2", 0, 16384, -16256, 35, -27, 0);
        chk_beat("t2", 1, 10, 40, 90, 160, 0);
        chk_beat("t2", 2, -1, 1, 0, -10000, 0);
        chk_beat("t2", 3, 16129, -127, -128, -4, 1);
        // T3: mode 1 accumulate
        q_data.delete(); q_last.delete();
        for (int k = 0; k < 4; k++) send(1, pk(3, 3, 3, 3), pk(-2, -2, -2, -2));
        drain();
        check("t3_count", q_data.size(), 1);
        chk_beat("t3", 0, -24, -24, -24, -24, 1);
        // T4: backpressure across two mode 0 maps
        q_data.delete(); q_last.delete();
        fork
            begin
                for (int k = 0; k < 8; k++) send(0, pk(k + 1, -(k + 1), 2 * k, 7), pk(3, 5, -1, k));
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                #1 snap = out_data;
                check("t4_stall_valid", longint'(out_valid), 1);
                check("t4_in_ready0", longint'(in_ready), 0);
                for (int s = 1; s < 5; s++) begin
                    @(negedge clk);
                    #1 check($sformatf("t4_hold%0d", s), longint'(out_data == snap), 1);
                    check($sformatf("t4_in_ready%0d", s), longint'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("t4_count", q_data.size(), 8);
        for (int k = 0; k < 8; k++)
            chk_beat("t4", k, 3 * (k + 1), -5 * (k + 1), -2 * k, 7 * k, (k == 3 || k == 7));
        // T5: mode change mid-map ignored, next map in mode 0 back-to-back
        q_data.delete(); q_last.delete();
        send(1, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
        send(1, pk(1, 2, 3, 4), pk(2, 2, 2, 2));
        send(0, pk(1, 2, 3, 4), pk(3, 3, 3, 3));
        send(0, pk(1, 2, 3, 4), pk(4, 4, 4, 4));
        for (int k = 0; k < 4; k++) send(0, pk(2, 2, 2, 2), pk(k, -k, 1, 0));
        drain();
        check("t5_count", q_data.size(), 5);
        chk_beat("t5", 0, 10, 20, 30, 40, 1);
        for (int k = 0; k < 4; k++) chk_beat("t5", k + 1, 2 * k, -2 * k, 2, 0, k == 3);
        // T6: worst-case accumulation, no wrap
        q_data.delete(); q_last.delete();
        for (int k = 0; k < 4; k++) send(1, pk(-128, -128, -128, -128), pk(-128, -128, -128, -128));
        drain();
        check("t6_count", q_data.size(), 1);
        chk_beat("t6", 0, 65536, 65536, 65536, 65536, 1);
        // T1: reset mid-map, next beat is beat 0
        send(0, pk(1, 1, 1, 1), pk(1, 1, 1, 1));
        send(0, pk(1, 1, 1, 1), pk(1, 1, 1, 1));
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t1_out_valid", longint'(out_valid), 0);
        check("t1_out_data", longint'(out_data != 0), 0);
        check("t1_in_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q_data.delete(); q_last.delete();
        for (int k = 0; k < 4; k++) send(1, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
        drain();
        check("t1_count", q_data.size(), 1);
        chk_beat("t1", 0, 4, 8, 12, 16, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
